// File: rtl/coke_pkg.sv
// Shared constants and state encoding for the vending interface (buyer and vending FSMs).
package coke_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPay  = 2'd1,
        StGap  = 2'd2,
        StWait = 2'd3
    } state_e;

    localparam int unsigned PRICE_DEFAULT = 3;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/coke_buyer.sv
// Customer-side initiator: pays PRICE units per coke, waits for coke_in, flags timeouts.
// Optional spurious-delivery checker enabled by defining COKE_BUYER_SPUR_CHK_EN.
module coke_buyer
    import coke_pkg::*;
#(
    parameter int unsigned PRICE   = PRICE_DEFAULT,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned GAP     = 0,
    parameter int unsigned TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [CNT_W-1:0] req_qty_i,
    output logic             pay_o,
    input  logic             coke_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] delivered_o
`ifdef COKE_BUYER_SPUR_CHK_EN
    ,
    output logic             spur_o,
    output logic [CNT_W-1:0] spur_cnt_o
`endif
);

    localparam int unsigned UnitW = cnt_width(PRICE);
    localparam int unsigned GapW  = cnt_width(GAP);
    localparam int unsigned TmrW  = cnt_width(TIMEOUT);

    state_e             state_q, state_d;
    logic [UnitW-1:0]   unit_q, unit_d;
    logic [GapW-1:0]    gap_q, gap_d;
    logic [TmrW-1:0]    tmr_q, tmr_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   deliv_q, deliv_d;
    logic               pay_q, done_q, done_d, err_q, err_d;

    always_comb begin
        state_d = state_q;
        unit_d  = unit_q;
        gap_d   = gap_q;
        tmr_d   = tmr_q;
        rem_d   = rem_q;
        deliv_d = deliv_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    deliv_d = '0;
                    rem_d   = req_qty_i;
                    unit_d  = '0;
                    if (req_qty_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StPay;
                    end
                end
            end
            StPay: begin
                unit_d = unit_q + UnitW'(1);
                if (unit_q == UnitW'(PRICE - 1)) begin
                    state_d = StWait;
                    tmr_d   = '0;
                end else if (GAP == 0) begin
                    state_d = StPay;
                end else begin
                    state_d = StGap;
                    gap_d   = '0;
                end
            end
            StGap: begin
                gap_d = gap_q + GapW'(1);
                if (gap_q == GapW'(GAP - 1)) begin
                    state_d = StPay;
                end
            end
            StWait: begin
                if (coke_in_i) begin
                    deliv_d = deliv_q + CNT_W'(1);
                    rem_d   = rem_q - CNT_W'(1);
                    unit_d  = '0;
                    // Next coke's first pay cycle directly follows the delivery cycle.
                    if (rem_q == CNT_W'(1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StPay;
                    end
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                    if (tmr_q == TmrW'(TIMEOUT - 1)) begin
                        state_d = StIdle;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            unit_q  <= '0;
            gap_q   <= '0;
            tmr_q   <= '0;
            rem_q   <= '0;
            deliv_q <= '0;
            pay_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            unit_q  <= unit_d;
            gap_q   <= gap_d;
            tmr_q   <= tmr_d;
            rem_q   <= rem_d;
            deliv_q <= deliv_d;
            pay_q   <= (state_d == StPay);
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign req_ready_o = (state_q == StIdle);
    assign busy_o      = (state_q != StIdle);
    assign pay_o       = pay_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign delivered_o = deliv_q;

`ifdef COKE_BUYER_SPUR_CHK_EN
    logic             spur_q;
    logic [CNT_W-1:0] spur_cnt_q;
    logic             spur_hit;

    // The state after an accepted delivery is never WAIT, so a repeat pulse is caught too.
    assign spur_hit = coke_in_i && (state_q != StWait);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spur_q     <= 1'b0;
            spur_cnt_q <= '0;
        end else begin
            spur_q <= spur_hit;
            if (spur_hit && (spur_cnt_q != '1)) begin
                spur_cnt_q <= spur_cnt_q + CNT_W'(1);
            end
        end
    end

    assign spur_o     = spur_q;
    assign spur_cnt_o = spur_cnt_q;
`endif

endmodule

// File: tb/tb_coke_buyer.sv
// Self-checking bench for coke_buyer: arithmetic order-timeline model plus a reactive vending model.
module tb_coke_buyer;

    localparam int P  = 3;
    localparam int TO = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_valid_g = 1'b0;
    logic [CW-1:0] req_qty = '0;
    logic          coke_in = 1'b0;

    logic          ready, pay, busy, done, err;
    logic [CW-1:0] deliv;
    logic          ready_g, pay_g, busy_g, done_g, err_g;
    logic [CW-1:0] deliv_g;
`ifdef COKE_BUYER_SPUR_CHK_EN
    logic          spur, spur_g;
    logic [CW-1:0] spur_cnt, spur_cnt_g;
`endif

    int n_vec = 0;
    int n_err = 0;
    int dly_q[$];
    int inj_cyc = -1;
    int spur_seen = 0;

    logic [511:0] exp_pay;
    int           exp_end;
    bit           exp_err;
    int           exp_deliv;

    coke_buyer #(.PRICE(P), .CNT_W(CW), .GAP(0), .TIMEOUT(TO)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(ready),
        .req_qty_i  (req_qty),
        .pay_o      (pay),
        .coke_in_i  (coke_in),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .delivered_o(deliv)
`ifdef COKE_BUYER_SPUR_CHK_EN
        ,
        .spur_o     (spur),
        .spur_cnt_o (spur_cnt)
`endif
    );

    coke_buyer #(.PRICE(P), .CNT_W(CW), .GAP(2), .TIMEOUT(TO)) u_dut_gap (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid_i(req_valid_g),
        .req_ready_o(ready_g),
        .req_qty_i  (req_qty),
        .pay_o      (pay_g),
        .coke_in_i  (coke_in),
        .busy_o     (busy_g),
        .done_o     (done_g),
        .err_o      (err_g),
        .delivered_o(deliv_g)
`ifdef COKE_BUYER_SPUR_CHK_EN
        ,
        .spur_o     (spur_g),
        .spur_cnt_o (spur_cnt_g)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Order timeline from the pricing rules: cycle 1 is the cycle after the accept edge.
    task automatic model(input int qty, input int g);
        int c;
        int d;
        exp_pay   = '0;
        exp_err   = 1'b0;
        exp_deliv = 0;
        c = 1;
        for (int i = 0; i < qty; i++) begin
            for (int u = 0; u < P; u++) begin
                exp_pay[c] = 1'b1;
                c++;
                if (u < P - 1) c += g;
            end
            d = (i < dly_q.size()) ? dly_q[i] : -1;
            if (d < 0 || d >= TO) begin
                c += TO;
                exp_err = 1'b1;
                break;
            end
            c += d + 1;
            exp_deliv++;
        end
        exp_end = c;
    endtask

    task automatic run_order(input int qty, input bit use_gap, input bit noisy);
        logic [511:0]  obs_pay;
        int            cyc, paid, deliver_at, coke_idx, end_cyc, dd;
        bit            ended, end_err, bad_ready;
        logic          p, d, e, b, r;
        logic [CW-1:0] dl;
        obs_pay = '0;
        model(qty, use_gap ? 2 : 0);
        req_qty = CW'(qty);
        if (use_gap) req_valid_g = 1'b1;
        else req_valid = 1'b1;
        step();
        req_valid   = 1'b0;
        req_valid_g = 1'b0;
        cyc = 1; paid = 0; deliver_at = -1; coke_idx = 0; end_cyc = -1;
        ended = 1'b0; end_err = 1'b0; bad_ready = 1'b0;
        p = 1'b0; d = 1'b0; e = 1'b0; b = 1'b0; r = 1'b0; dl = '0;
        while (!ended && cyc < 500) begin
            p  = use_gap ? pay_g   : pay;
            d  = use_gap ? done_g  : done;
            e  = use_gap ? err_g   : err;
            b  = use_gap ? busy_g  : busy;
            r  = use_gap ? ready_g : ready;
            dl = use_gap ? deliv_g : deliv;
`ifdef COKE_BUYER_SPUR_CHK_EN
            if (!use_gap && spur) spur_seen++;
`endif
            if (p) obs_pay[cyc] = 1'b1;
            if (d || e) begin
                ended   = 1'b1;
                end_cyc = cyc;
                end_err = e;
                req_valid   = 1'b0;
                req_valid_g = 1'b0;
                coke_in     = 1'b0;
            end else begin
                if (p) begin
                    paid++;
                    if (paid == P) begin
                        paid = 0;
                        dd = (coke_idx < dly_q.size()) ? dly_q[coke_idx] : -1;
                        coke_idx++;
                        deliver_at = (dd < 0) ? -1 : cyc + 1 + dd;
                    end
                end
                if (r || !b) bad_ready = 1'b1;
                if (noisy) begin
                    if (use_gap) req_valid_g = 1'($urandom_range(0, 1));
                    else req_valid = 1'($urandom_range(0, 1));
                    req_qty = CW'($urandom);
                end
                coke_in = (cyc == deliver_at) || (cyc == inj_cyc);
                step();
                cyc++;
            end
        end
        n_vec++;
        if (!ended) begin
            n_err++;
            $display("FAIL order_timeout: no done/err within %0d cycles (qty %0d)", cyc, qty);
        end
        n_vec++;
        if (end_cyc !== exp_end) begin
            n_err++;
            $display("FAIL end_cycle: got %0d want %0d (qty %0d gap %0d)", end_cyc, exp_end,
                     qty, use_gap);
        end
        n_vec++;
        if ({d, e} !== (exp_err ? 2'b01 : 2'b10)) begin
            n_err++;
            $display("FAIL done_err: got done=%0b err=%0b want err=%0b", d, e, exp_err);
        end
        n_vec++;
        if (obs_pay !== exp_pay) begin
            n_err++;
            $display("FAIL pay_pattern: got %h want %h", obs_pay[255:0], exp_pay[255:0]);
        end
        n_vec++;
        if (dl !== CW'(exp_deliv)) begin
            n_err++;
            $display("FAIL delivered: got %0d want %0d", dl, exp_deliv);
        end
        n_vec++;
        if (bad_ready || r !== 1'b1 || b !== 1'b0) begin
            n_err++;
            $display("FAIL ready_busy: bad_during=%0b end ready=%0b busy=%0b want 0/1/0",
                     bad_ready, r, b);
        end
        step();
        d  = use_gap ? done_g  : done;
        e  = use_gap ? err_g   : err;
        dl = use_gap ? deliv_g : deliv;
`ifdef COKE_BUYER_SPUR_CHK_EN
        if (!use_gap && spur) spur_seen++;
`endif
        n_vec++;
        if (d !== 1'b0 || e !== 1'b0 || dl !== CW'(exp_deliv)) begin
            n_err++;
            $display("FAIL pulse_hold: got done=%0b err=%0b deliv=%0d want 0 0 %0d",
                     d, e, dl, exp_deliv);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_vec++;
        if ({pay, done, err, busy, ready} !== 5'b00001 || deliv !== '0) begin
            n_err++;
            $display("FAIL %s: got pay=%0b done=%0b err=%0b busy=%0b ready=%0b deliv=%0d want 0 0 0 0 1 0",
                     tag, pay, done, err, busy, ready, deliv);
        end
`ifdef COKE_BUYER_SPUR_CHK_EN
        n_vec++;
        if (spur !== 1'b0 || spur_cnt !== '0) begin
            n_err++;
            $display("FAIL %s_spur: got spur=%0b cnt=%0d want 0 0", tag, spur, spur_cnt);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        dly_q = {0};
        run_order(1, 1'b0, 1'b0);
    endtask

    task automatic test_multi();
        dly_q = {0, 0, 0};
        run_order(3, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        dly_q = {-1};
        run_order(2, 1'b0, 1'b0);
    endtask

    task automatic test_gap();
        dly_q = {0};
        run_order(1, 1'b1, 1'b0);
    endtask

    task automatic test_zero_qty();
        dly_q.delete();
        run_order(0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        dly_q = {1, 2};
        run_order(2, 1'b0, 1'b1);
        dly_q = {3, 0, 1};
        run_order(3, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        req_qty   = CW'(3);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        step();
        coke_in = 1'b1;
        step();
        coke_in = 1'b0;
        step();
        n_vec++;
        if (pay !== 1'b1 || deliv !== CW'(1)) begin
            n_err++;
            $display("FAIL mid_pre: got pay=%0b deliv=%0d want 1 1", pay, deliv);
        end
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        dly_q = {0};
        run_order(1, 1'b0, 1'b0);
    endtask

`ifdef COKE_BUYER_SPUR_CHK_EN
    task automatic test_spur();
        logic [CW-1:0] before;
        before  = spur_cnt;
        coke_in = 1'b1;
        step();
        coke_in = 1'b0;
        n_vec++;
        if (spur !== 1'b1) begin
            n_err++;
            $display("FAIL spur_idle: got %0b want 1", spur);
        end
        spur_seen = 0;
        inj_cyc   = 2;
        dly_q     = {0};
        run_order(1, 1'b0, 1'b0);
        inj_cyc = -1;
        n_vec++;
        if (spur_seen !== 1 || spur_cnt !== before + CW'(2)) begin
            n_err++;
            $display("FAIL spur_cnt: got pulses=%0d cnt=%0d want 1 %0d", spur_seen, spur_cnt,
                     before + CW'(2));
        end
    endtask
`endif

    task automatic test_random();
        int qty;
        for (int k = 0; k < 25; k++) begin
            qty = $urandom_range(0, 12);
            dly_q.delete();
            for (int i = 0; i < qty; i++) begin
                if ($urandom_range(0, 7) == 0) dly_q.push_back(-1);
                else dly_q.push_back($urandom_range(0, TO - 1));
            end
            run_order(qty, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_timeout();
        test_gap();
        test_zero_qty();
        test_back_to_back();
        test_reset_mid();
`ifdef COKE_BUYER_SPUR_CHK_EN
        test_spur();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
